// File: rtl/detector_colisao.sv
// detector_colisao: once per frame, checks the player car against three
// opponent cars with axis-aligned box overlap, manages lives, the
// invulnerability window after a hit, and the sticky game-over flag.
// Optional frame score counter enabled by defining CONTADOR_PONTOS_EN.
module detector_colisao #(
  parameter int CAR_W         = 40,
  parameter int CAR_H         = 60,
  parameter int VIDAS_INI     = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [9:0]  jogador_x,
  input  logic [8:0]  jogador_y,
  input  logic [9:0]  oponente1_x,
  input  logic [8:0]  oponente1_y,
  input  logic [9:0]  oponente2_x,
  input  logic [8:0]  oponente2_y,
  input  logic [9:0]  oponente3_x,
  input  logic [8:0]  oponente3_y,
  output logic        colisao,
  output logic [1:0]  indice_colisao,
  output logic [2:0]  vidas,
  output logic        invulneravel,
  output logic        game_over,
  output logic        ocupado,
  output logic [15:0] pontos
);

  typedef enum logic [1:0] {IDLE, CHECK, RESOLVE, FIM} estado_t;

  estado_t         estado;
  logic [9:0]      snap_jx;
  logic [8:0]      snap_jy;
  logic [2:0][9:0] snap_ox;
  logic [2:0][8:0] snap_oy;
  logic [1:0]      idx;
  logic [2:0]      mascara;
  logic [7:0]      cnt_invuln;

  logic [9:0]         ox_sel;
  logic [8:0]         oy_sel;
  logic signed [10:0] dx, dy;
  logic [10:0]        adx, ady;
  logic               hit;

  // Box-overlap test for the opponent selected by idx (snapshot values only).
  // Differences are 11-bit signed so they never wrap; touching edges are no hit.
  always_comb begin
    ox_sel = snap_ox[idx];
    oy_sel = snap_oy[idx];
    dx     = $signed({1'b0, snap_jx}) - $signed({1'b0, ox_sel});
    dy     = $signed({2'b00, snap_jy}) - $signed({2'b00, oy_sel});
    adx    = dx[10] ? 11'(-dx) : 11'(dx);
    ady    = dy[10] ? 11'(-dy) : 11'(dy);
    hit    = (adx < 11'(CAR_W)) && (ady < 11'(CAR_H));
  end

  assign invulneravel = (cnt_invuln != 8'd0);

  // Scan FSM: snapshot on tick, one opponent per clock, resolve lives/immunity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado         <= IDLE;
      snap_jx        <= '0;
      snap_jy        <= '0;
      snap_ox        <= '0;
      snap_oy        <= '0;
      idx            <= 2'd0;
      mascara        <= 3'b000;
      cnt_invuln     <= 8'd0;
      colisao        <= 1'b0;
      indice_colisao <= 2'd0;
      vidas          <= 3'(VIDAS_INI);
      game_over      <= 1'b0;
      ocupado        <= 1'b0;
    end else begin
      colisao <= 1'b0;
      case (estado)
        IDLE: begin
          if (frame_tick) begin
            snap_jx    <= jogador_x;
            snap_jy    <= jogador_y;
            snap_ox[0] <= oponente1_x;
            snap_oy[0] <= oponente1_y;
            snap_ox[1] <= oponente2_x;
            snap_oy[1] <= oponente2_y;
            snap_ox[2] <= oponente3_x;
            snap_oy[2] <= oponente3_y;
            mascara    <= 3'b000;
            idx        <= 2'd0;
            ocupado    <= 1'b1;
            estado     <= CHECK;
          end
        end
        CHECK: begin
          mascara[idx] <= hit;
          if (idx == 2'd2) estado <= RESOLVE;
          else             idx    <= idx + 2'd1;
        end
        RESOLVE: begin
          ocupado <= 1'b0;
          estado  <= IDLE;
          if (mascara != 3'b000 && cnt_invuln == 8'd0 && vidas != 3'd0) begin
            colisao        <= 1'b1;
            indice_colisao <= mascara[0] ? 2'd1 : (mascara[1] ? 2'd2 : 2'd3);
            vidas          <= vidas - 3'd1;
            if (vidas == 3'd1) begin
              game_over <= 1'b1;
              estado    <= FIM;
            end else begin
              cnt_invuln <= 8'(INVULN_FRAMES);
            end
          end else if (cnt_invuln != 8'd0) begin
            cnt_invuln <= cnt_invuln - 8'd1;
          end
        end
        FIM: begin
          // Terminal until reset; frame ticks are ignored here.
        end
        default: estado <= IDLE;
      endcase
    end
  end

`ifdef CONTADOR_PONTOS_EN
  logic [15:0] pontos_cnt;

  // Frames survived: counts ticks accepted in IDLE, saturating, frozen in FIM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pontos_cnt <= 16'd0;
    else if (estado == IDLE && frame_tick && !game_over && pontos_cnt != 16'hFFFF)
      pontos_cnt <= pontos_cnt + 16'd1;
  end

  assign pontos = pontos_cnt;
`else
  assign pontos = 16'd0;
`endif

endmodule

// File: tb/tb_detector_colisao.sv
// Self-checking bench for detector_colisao. Two instances share stimulus:
// dut_a (3 lives, 2-frame immunity) and dut_b (1 life) for game-over.
module tb_detector_colisao;

`ifdef CONTADOR_PONTOS_EN
  localparam bit PONTOS_ON = 1'b1;
`else
  localparam bit PONTOS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] jx, o1x, o2x, o3x;
  logic [8:0] jy, o1y, o2y, o3y;

  logic        colisao_a, inv_a, go_a, ocup_a;
  logic [1:0]  idx_a;
  logic [2:0]  vidas_a;
  logic [15:0] pontos_a;
  logic        colisao_b, inv_b, go_b, ocup_b;
  logic [1:0]  idx_b;
  logic [2:0]  vidas_b;
  logic [15:0] pontos_b;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int pulses;
    int idx;
    int vidas;
    bit inv;
  } exp_t;
  exp_t exp_q[$];

  // per-frame observations
  int npa, npb, oca, ocb, fpa;

  always #5 clk = ~clk;

  detector_colisao #(.CAR_W(40), .CAR_H(60), .VIDAS_INI(3), .INVULN_FRAMES(2)) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .jogador_x(jx), .jogador_y(jy),
    .oponente1_x(o1x), .oponente1_y(o1y),
    .oponente2_x(o2x), .oponente2_y(o2y),
    .oponente3_x(o3x), .oponente3_y(o3y),
    .colisao(colisao_a), .indice_colisao(idx_a), .vidas(vidas_a),
    .invulneravel(inv_a), .game_over(go_a), .ocupado(ocup_a), .pontos(pontos_a)
  );

  detector_colisao #(.CAR_W(40), .CAR_H(60), .VIDAS_INI(1), .INVULN_FRAMES(2)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .jogador_x(jx), .jogador_y(jy),
    .oponente1_x(o1x), .oponente1_y(o1y),
    .oponente2_x(o2x), .oponente2_y(o2y),
    .oponente3_x(o3x), .oponente3_y(o3y),
    .colisao(colisao_b), .indice_colisao(idx_b), .vidas(vidas_b),
    .invulneravel(inv_b), .game_over(go_b), .ocupado(ocup_b), .pontos(pontos_b)
  );

  task automatic set_far();
    jx = 10'd300; jy = 9'd400;
    o1x = 10'd600; o1y = 9'd0;
    o2x = 10'd0;   o2y = 9'd0;
    o3x = 10'd600; o3y = 9'd100;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // One frame: tick sampled on the next posedge, then 10 observed cycles.
  task automatic run_frame(input int retick_at, input bit scramble);
    npa = 0; npb = 0; oca = 0; ocb = 0; fpa = -1;
    @(negedge clk); frame_tick = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      frame_tick = (c == retick_at);
      if (scramble && c == 1) set_far();
      if (colisao_a) begin npa++; if (fpa < 0) fpa = c; end
      if (colisao_b) npb++;
      if (ocup_a) oca++;
      if (ocup_b) ocb++;
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    tests++; if (colisao_a !== 1'b0) begin fails++; $display("FAIL reset_colisao got %0d want 0", colisao_a); end
    tests++; if (idx_a !== 2'd0) begin fails++; $display("FAIL reset_indice got %0d want 0", idx_a); end
    tests++; if (vidas_a !== 3'd3) begin fails++; $display("FAIL reset_vidas got %0d want 3", vidas_a); end
    tests++; if (vidas_b !== 3'd1) begin fails++; $display("FAIL reset_vidas_b got %0d want 1", vidas_b); end
    tests++; if ({inv_a, go_a, ocup_a} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {inv_a, go_a, ocup_a}); end
    tests++; if (pontos_a !== 16'd0) begin fails++; $display("FAIL reset_pontos got %0d want 0", pontos_a); end
    e = '{0, 0, 3, 1'b0};
    exp_q.push_back(e);
  endtask

  // Player (300,400) vs (178,150),(284,0),(391,340): opp3 dx=91 -> no hit.
  task automatic test_no_hit();
    exp_t e;
    jx = 10'd300; jy = 9'd400;
    o1x = 10'd178; o1y = 9'd150;
    o2x = 10'd284; o2y = 9'd0;
    o3x = 10'd391; o3y = 9'd340;
    run_frame(0, 1'b0);
    e = exp_q.pop_front();
    tests++; if (npa !== e.pulses) begin fails++; $display("FAIL no_hit_pulses got %0d want %0d", npa, e.pulses); end
    tests++; if (vidas_a !== 3'(e.vidas)) begin fails++; $display("FAIL no_hit_vidas got %0d want %0d", vidas_a, e.vidas); end
    tests++; if (oca !== 4) begin fails++; $display("FAIL no_hit_ocupado_cycles got %0d want 4", oca); end
    tests++; if (idx_a !== 2'(e.idx)) begin fails++; $display("FAIL no_hit_indice got %0d want %0d", idx_a, e.idx); end
  endtask

  // opp2 at (284,360): dx=16, dy=40 -> hit on opponent 2.
  task automatic test_hit();
    exp_t e;
    set_far();
    o2x = 10'd284; o2y = 9'd360;
    exp_q.push_back('{1, 2, 2, 1'b1});
    run_frame(0, 1'b0);
    e = exp_q.pop_front();
    tests++; if (npa !== e.pulses) begin fails++; $display("FAIL hit_pulses got %0d want %0d", npa, e.pulses); end
    tests++; if (fpa !== 5) begin fails++; $display("FAIL hit_latency got cycle %0d want 5", fpa); end
    tests++; if (idx_a !== 2'(e.idx)) begin fails++; $display("FAIL hit_indice got %0d want %0d", idx_a, e.idx); end
    tests++; if (vidas_a !== 3'(e.vidas)) begin fails++; $display("FAIL hit_vidas got %0d want %0d", vidas_a, e.vidas); end
    tests++; if (inv_a !== e.inv) begin fails++; $display("FAIL hit_invuln got %0d want %0d", inv_a, e.inv); end
  endtask

  // Overlap held with 2-frame immunity: n+1,n+2 ignored, n+3 hit, n+4 ignored.
  task automatic test_invuln();
    exp_t e;
    exp_q.push_back('{0, 2, 2, 1'b1});
    exp_q.push_back('{0, 2, 2, 1'b0});
    exp_q.push_back('{1, 2, 1, 1'b1});
    exp_q.push_back('{0, 2, 1, 1'b1});
    for (int f = 1; f <= 4; f++) begin
      run_frame(0, 1'b0);
      e = exp_q.pop_front();
      tests++; if (npa !== e.pulses) begin fails++; $display("FAIL invuln_f%0d_pulses got %0d want %0d", f, npa, e.pulses); end
      tests++; if (vidas_a !== 3'(e.vidas)) begin fails++; $display("FAIL invuln_f%0d_vidas got %0d want %0d", f, vidas_a, e.vidas); end
      tests++; if (inv_a !== e.inv) begin fails++; $display("FAIL invuln_f%0d_inv got %0d want %0d", f, inv_a, e.inv); end
    end
  endtask

  // opp1 and opp3 overlap, opp2 at dx exactly 40 -> index 1, single decrement.
  task automatic test_multi();
    exp_t e;
    do_reset();
    set_far();
    o1x = 10'd310; o1y = 9'd410;
    o2x = 10'd340; o2y = 9'd400;
    o3x = 10'd290; o3y = 9'd390;
    exp_q.push_back('{1, 1, 2, 1'b1});
    run_frame(0, 1'b0);
    e = exp_q.pop_front();
    tests++; if (npa !== e.pulses) begin fails++; $display("FAIL multi_pulses got %0d want %0d", npa, e.pulses); end
    tests++; if (idx_a !== 2'(e.idx)) begin fails++; $display("FAIL multi_indice got %0d want %0d", idx_a, e.idx); end
    tests++; if (vidas_a !== 3'(e.vidas)) begin fails++; $display("FAIL multi_vidas got %0d want %0d", vidas_a, e.vidas); end
  endtask

  // Single-opponent boundary cases, each from reset with the others far.
  task automatic test_boundary();
    exp_t e;
    int which [5] = '{2, 1, 2, 3, 1};
    int bx    [5] = '{340, 260, 300, 261, 339};
    int by    [5] = '{400, 400, 460, 341, 459};
    int bp    [5] = '{0, 0, 0, 1, 1};
    int bi    [5] = '{0, 0, 0, 3, 1};
    for (int k = 0; k < 5; k++) begin
      do_reset();
      set_far();
      case (which[k])
        1: begin o1x = 10'(bx[k]); o1y = 9'(by[k]); end
        2: begin o2x = 10'(bx[k]); o2y = 9'(by[k]); end
        default: begin o3x = 10'(bx[k]); o3y = 9'(by[k]); end
      endcase
      exp_q.push_back('{bp[k], bi[k], 3 - bp[k], bp[k] != 0});
      run_frame(0, 1'b0);
      e = exp_q.pop_front();
      tests++; if (npa !== e.pulses) begin fails++; $display("FAIL boundary%0d_pulses got %0d want %0d", k, npa, e.pulses); end
      tests++; if (idx_a !== 2'(e.idx)) begin fails++; $display("FAIL boundary%0d_indice got %0d want %0d", k, idx_a, e.idx); end
      tests++; if (vidas_a !== 3'(e.vidas)) begin fails++; $display("FAIL boundary%0d_vidas got %0d want %0d", k, vidas_a, e.vidas); end
    end
  endtask

  // Positions move away and a second tick arrives mid-scan: snapshot rules, tick dropped.
  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    set_far();
    o2x = 10'd284; o2y = 9'd360;
    exp_q.push_back('{1, 2, 2, 1'b1});
    run_frame(2, 1'b1);
    e = exp_q.pop_front();
    tests++; if (npa !== e.pulses) begin fails++; $display("FAIL b2b_pulses got %0d want %0d", npa, e.pulses); end
    tests++; if (oca !== 4) begin fails++; $display("FAIL b2b_ocupado_cycles got %0d want 4", oca); end
    tests++; if (idx_a !== 2'(e.idx)) begin fails++; $display("FAIL b2b_indice got %0d want %0d", idx_a, e.idx); end
  endtask

  task automatic test_game_over();
    do_reset();
    set_far();
    o2x = 10'd284; o2y = 9'd360;
    run_frame(0, 1'b0);
    tests++; if (npb !== 1) begin fails++; $display("FAIL go_pulse got %0d want 1", npb); end
    tests++; if (go_b !== 1'b1) begin fails++; $display("FAIL go_flag got %0d want 1", go_b); end
    tests++; if (vidas_b !== 3'd0) begin fails++; $display("FAIL go_vidas got %0d want 0", vidas_b); end
    run_frame(0, 1'b0);
    tests++; if (npb !== 0) begin fails++; $display("FAIL go_after_pulse got %0d want 0", npb); end
    tests++; if (ocb !== 0) begin fails++; $display("FAIL go_after_ocupado got %0d want 0", ocb); end
    tests++; if (vidas_b !== 3'd0 || go_b !== 1'b1) begin fails++; $display("FAIL go_sticky got vidas %0d go %0d want 0 1", vidas_b, go_b); end
    tests++; if (pontos_b !== (PONTOS_ON ? 16'd1 : 16'd0)) begin fails++; $display("FAIL go_pontos_frozen got %0d want %0d", pontos_b, PONTOS_ON ? 1 : 0); end
    // reset asserted in the middle of a dut_a scan
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    tests++; if (ocup_a !== 1'b1) begin fails++; $display("FAIL midscan_busy got %0d want 1", ocup_a); end
    reset = 1'b1;
    #1;
    tests++; if ({ocup_a, colisao_a, inv_a, idx_a} !== 5'b0) begin fails++; $display("FAIL midscan_reset_flags got %b want 00000", {ocup_a, colisao_a, inv_a, idx_a}); end
    tests++; if (vidas_a !== 3'd3 || vidas_b !== 3'd1) begin fails++; $display("FAIL midscan_reset_vidas got %0d/%0d want 3/1", vidas_a, vidas_b); end
    tests++; if (go_b !== 1'b0 || pontos_b !== 16'd0) begin fails++; $display("FAIL midscan_reset_go got %0d pontos %0d want 0 0", go_b, pontos_b); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_pontos();
    do_reset();
    set_far();
    for (int f = 0; f < 5; f++) run_frame(0, 1'b0);
    tests++; if (pontos_a !== (PONTOS_ON ? 16'd5 : 16'd0)) begin fails++; $display("FAIL pontos_count got %0d want %0d", pontos_a, PONTOS_ON ? 5 : 0); end
    tests++; if (vidas_a !== 3'd3) begin fails++; $display("FAIL pontos_vidas got %0d want 3", vidas_a); end
`ifdef CONTADOR_PONTOS_EN
    @(negedge clk); force dut_a.pontos_cnt = 16'hFFFE;
    @(negedge clk); release dut_a.pontos_cnt;
    for (int f = 0; f < 3; f++) run_frame(0, 1'b0);
    tests++; if (pontos_a !== 16'hFFFF) begin fails++; $display("FAIL pontos_saturate got %0d want 65535", pontos_a); end
`endif
  endtask

  initial begin
    set_far();
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_no_hit();
    test_hit();
    test_invuln();
    test_multi();
    test_boundary();
    test_back_to_back();
    test_game_over();
    test_pontos();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
